// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, the op encoding and the wait-counter sizing.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // The counter only ever holds WAIT_CYCLES-1, so clog2(WAIT_CYCLES) bits suffice; never fewer than one.
    function automatic int wait_cnt_width(input int wait_cycles);
        return (wait_cycles <= 2) ? 1 : $clog2(wait_cycles);
    endfunction

    localparam int DEFAULT_WAIT_CYCLES = 2;
    localparam int WAIT_CNT_W          = wait_cnt_width(DEFAULT_WAIT_CYCLES);

endpackage

// File: rtl/dmem_responder_array.sv
// Word-addressed storage: synchronous write, combinational read, synchronous clear.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int IDX_W      = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage update: reset clears every word and takes priority over a pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_idx] <= wr_data;
        end else begin
            mem[wr_idx] <= mem[wr_idx];
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Load/store data-memory responder: accepts a request, waits WAIT_CYCLES,
// then pulses ready (and err for illegal requests) with registered read data.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  ready,
    output logic                  busy,
    output logic                  err
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int CNT_W = wait_cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nxt;
    logic [IDX_W-1:0]      cap_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] cap_data;
    logic [DATA_WIDTH-1:0] rd_word;
    op_t                   cap_op;
    op_t                   op_nxt;
    logic                  cap_illegal;
    logic                  illegal_nxt;
    logic                  req;
    logic                  req_illegal;
    logic                  accept;
    logic                  wr_en;
    logic                  done_entry;

    assign req         = memRead | memWrite;
    assign req_illegal = (memRead & memWrite) | (addr[1:0] != 2'b00);

    // Next-state, counter and the view of the transaction being completed.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_BUSY;
                        count_nxt = CNT_LOAD;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (count == '0) begin
                    state_nxt = ST_DONE;
                end else begin
                    count_nxt = count - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                count_nxt = '0;
            end
        endcase

        // With zero wait states DONE is entered on the accept edge, so use the live request.
        if (accept) begin
            op_nxt      = memWrite ? OP_WR : OP_RD;
            illegal_nxt = req_illegal;
            rd_idx      = addr[ADDR_WIDTH-1:2];
        end else begin
            op_nxt      = cap_op;
            illegal_nxt = cap_illegal;
            rd_idx      = cap_idx;
        end

        done_entry = (state_nxt == ST_DONE) && (state != ST_DONE);
        wr_en      = (state == ST_DONE) && (cap_op == OP_WR) && !cap_illegal;
    end

    // FSM state, capture registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            count       <= '0;
            cap_idx     <= '0;
            cap_data    <= '0;
            cap_op      <= OP_RD;
            cap_illegal <= 1'b0;
            readData    <= '0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (accept) begin
                cap_idx     <= addr[ADDR_WIDTH-1:2];
                cap_data    <= writeData;
                cap_op      <= op_nxt;
                cap_illegal <= req_illegal;
            end else begin
                cap_idx     <= cap_idx;
                cap_data    <= cap_data;
                cap_op      <= cap_op;
                cap_illegal <= cap_illegal;
            end
            busy  <= (state_nxt != ST_IDLE);
            ready <= (state_nxt == ST_DONE);
            err   <= (state_nxt == ST_DONE) && illegal_nxt;
            // Load data is latched on DONE entry so it is valid alongside ready.
            if (done_entry && (op_nxt == OP_RD) && !illegal_nxt) begin
                readData <= rd_word;
            end else begin
                readData <= readData;
            end
        end
    end

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .we      (wr_en),
        .wr_idx  (cap_idx),
        .wr_data (cap_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_word)
    );

endmodule
